// File: rtl/sgmii_status_dprintf.sv
// sgmii_status_dprintf: captures SGMII measure/eye status pulses and issues them as arbitrated dprintf requests
module sgmii_status_dprintf #(
  parameter logic [8:0]  MIN_DELAY         = 9'd16,
  parameter logic [23:0] EYE_REPEAT_CYCLES = 24'd1000000,
  parameter logic [15:0] MEASURE_ADDR      = 16'd80,
  parameter logic [15:0] EYE_ADDR          = 16'd100
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        measure_response__valid,
  input  logic        measure_response__abort,
  input  logic        measure_response__initial_value,
  input  logic [8:0]  measure_response__delay,
  input  logic [8:0]  measure_response__initial_delay,
  input  logic        eye_track_response__eye_data_valid,
  input  logic [8:0]  eye_track_response__eye_width,
  input  logic [8:0]  eye_track_response__eye_center,
  input  logic [8:0]  eye_track_response__data_delay,
  output logic        dprintf_req__valid,
  output logic [15:0] dprintf_req__address,
  output logic [63:0] dprintf_req__data_0,
  output logic [63:0] dprintf_req__data_1,
  output logic [63:0] dprintf_req__data_2,
  output logic [63:0] dprintf_req__data_3,
  input  logic        dprintf_ack,
  output logic [15:0] dropped_count
);
  typedef enum logic {IDLE, REQ} state_t;
  state_t      state;
  logic        pend_m, pend_e, last_m;
  logic [63:0] data_m, data_e;
  logic [26:0] last_eye, eye_now;
  logic [23:0] holdoff;
  logic        cap_m, cap_e, launch, sel_m, launch_m, launch_e, drop_m, drop_e;
  logic [16:0] drop_sum;
  assign eye_now  = {eye_track_response__eye_width, eye_track_response__eye_center, eye_track_response__data_delay};
  assign cap_m    = measure_response__valid && (measure_response__delay > MIN_DELAY);
  assign cap_e    = eye_track_response__eye_data_valid && (eye_now != last_eye || holdoff >= EYE_REPEAT_CYCLES);
  assign launch   = (state == IDLE) && (pend_m || pend_e);
  // Both pending: alternate away from the last served source
  assign sel_m    = pend_m && (!pend_e || !last_m);
  assign launch_m = launch && sel_m;
  assign launch_e = launch && !sel_m;
  assign drop_m   = cap_m && pend_m && !launch_m;
  assign drop_e   = cap_e && pend_e && !launch_e;
  assign drop_sum = {1'b0, dropped_count} + {16'd0, drop_m} + {16'd0, drop_e};
  assign dprintf_req__data_1 = '1;
  assign dprintf_req__data_2 = '1;
  assign dprintf_req__data_3 = '1;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state                <= IDLE;
      pend_m               <= 1'b0;
      pend_e               <= 1'b0;
      last_m               <= 1'b0;
      data_m               <= '0;
      data_e               <= '0;
      last_eye             <= '0;
      holdoff              <= '0;
      dropped_count        <= '0;
      dprintf_req__valid   <= 1'b0;
      dprintf_req__address <= '0;
      dprintf_req__data_0  <= '0;
    end else begin
      pend_m        <= cap_m | (pend_m & ~launch_m);
      pend_e        <= cap_e | (pend_e & ~launch_e);
      holdoff       <= launch_e ? '0 : holdoff + {23'd0, ~&holdoff};
      dropped_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      if (cap_m)
        data_m <= {32'h20202087, 7'h0, measure_response__initial_delay, 3'h0, measure_response__delay,
                   1'b0, measure_response__initial_value, measure_response__abort, 1'b1};
      if (cap_e) begin
        data_e   <= {8'h89, 3'h0, eye_track_response__eye_width, 3'h0, eye_track_response__eye_center,
                     3'h0, eye_track_response__data_delay, 4'h0, 8'hFF, 8'h00};
        last_eye <= eye_now;
      end
      if (launch) begin
        state                <= REQ;
        dprintf_req__valid   <= 1'b1;
        dprintf_req__address <= sel_m ? MEASURE_ADDR : EYE_ADDR;
        dprintf_req__data_0  <= sel_m ? data_m : data_e;
        last_m               <= sel_m;
      end else if (state == REQ && dprintf_ack) begin
        state              <= IDLE;
        dprintf_req__valid <= 1'b0;
      end
    end
  end
endmodule
